lcd_driver: RTL and testbench

Display back end for the vending controller. Consumes the 4-bit message code produced by the selector state machine and drives an HD44780-compatible character LCD in 8-bit write-only mode. It runs the power-up initialisation, then rewrites line 1 (16 characters) from a message ROM whenever the code changes. It sits between the selector FSM and the board LCD header and is the receiving end of the selector's message-code interface.

---
 rtl/lcd_pkg.sv | 50 +++++
 rtl/lcd_bus_cycle.sv | 81 ++++++++
 rtl/lcd_driver.sv | 146 ++++++++++++++
 tb/tb_lcd_driver.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 back end: command bytes, FSM state
// encodings and the 16-character message ROM for line 1.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] HOME_L1  = 8'h80;
  localparam logic [7:0] SPACE    = 8'h20;

  typedef enum logic [2:0] {
    ST_PWRUP, ST_INIT, ST_IDLE, ST_CLEAR, ST_HOME, ST_CHARS
  } lcd_state_t;

  typedef enum logic [1:0] {
    BUS_IDLE, BUS_SETUP, BUS_STROBE, BUS_WAIT
  } bus_phase_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] n);
    logic [7:0] c;
    case (n)
      2'd0:    c = FUNC_SET;
      2'd1:    c = DISP_ON;
      2'd2:    c = ENTRY;
      default: c = CLEAR;
    endcase
    return c;
  endfunction

  // Codes without text show a blank line; character 0 is the leftmost.
  function automatic logic [7:0] msg_char(input logic [3:0] code, input logic [3:0] idx);
    logic [127:0] line;
    case (code)
      4'h0:    line = "INSERT COINS    ";
      4'h1:    line = "SELECT ITEM     ";
      4'h2:    line = "VENDING...      ";
      4'h3:    line = "THANK YOU       ";
      4'h4:    line = "SOLD OUT        ";
      4'h5:    line = "EXACT CHANGE    ";
      4'h6:    line = "RETURNING COINS ";
      4'h7:    line = "TAKE CHANGE     ";
      4'h8:    line = "SERVICE MODE    ";
      4'h9:    line = "ERROR - CALL    ";
      default: line = {16{SPACE}};
    endcase
    return line[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One LCD write: SETUP (bus driven, e low), STROBE (e high), WAIT (e low).
// done pulses in the last WAIT clock so the next start can follow back-to-back.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int E_CYCLES = 4,
  parameter int CMD_WAIT = 2000,
  parameter int CLR_WAIT = 80000,
  parameter int CW       = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] wr_byte,
  input  logic       rs,
  input  logic       is_clear,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  bus_phase_t    phase_reg;
  logic [CW-1:0] cnt_reg;
  logic          clr_reg;
  logic          e_reg;
  logic          rs_reg;
  logic [7:0]    data_reg;
  logic [CW-1:0] wait_last;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign wait_last = clr_reg ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
  assign done      = (phase_reg == BUS_WAIT) && (cnt_reg == wait_last);
  assign lcd_rs    = rs_reg;
  assign lcd_e     = e_reg;
  assign lcd_data  = data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_reg <= BUS_IDLE;
      cnt_reg   <= '0;
      clr_reg   <= 1'b0;
      e_reg     <= 1'b0;
      rs_reg    <= 1'b0;
      data_reg  <= 8'h00;
    end else if (start) begin
      phase_reg <= BUS_SETUP;
      cnt_reg   <= '0;
      clr_reg   <= is_clear;
      e_reg     <= 1'b0;
      rs_reg    <= rs;
      data_reg  <= wr_byte;
    end else begin
      case (phase_reg)
        BUS_SETUP: begin
          phase_reg <= BUS_STROBE;
          e_reg     <= 1'b1;
          cnt_reg   <= '0;
        end
        BUS_STROBE: begin
          if (cnt_reg == CW'(E_CYCLES - 1)) begin
            phase_reg <= BUS_WAIT;
            e_reg     <= 1'b0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= sat_inc(cnt_reg);
          end
        end
        BUS_WAIT: begin
          if (done) phase_reg <= BUS_IDLE;
          else      cnt_reg   <= sat_inc(cnt_reg);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_driver.sv
// HD44780 back end: power-up init, then rewrites line 1 from the message ROM
// whenever the selector's message code differs from what is on screen.
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int E_CYCLES   = 4,
  parameter int CMD_WAIT   = 2000,
  parameter int CLR_WAIT   = 80000,
  parameter int PWRUP_WAIT = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] code,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy
);

  localparam int MAX_A = (E_CYCLES > CMD_WAIT) ? E_CYCLES : CMD_WAIT;
  localparam int MAX_B = (CLR_WAIT > PWRUP_WAIT) ? CLR_WAIT : PWRUP_WAIT;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P) + 1;

  lcd_state_t    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    idx_reg;
  logic [3:0]    shown_reg;
  logic          shown_valid_reg;
  logic          busy_reg;

  logic       start;
  logic [7:0] wr_byte;
  logic       wr_rs;
  logic       is_clear;
  logic       done;
  logic       mismatch;

  assign mismatch = !shown_valid_reg || (code != shown_reg);
  assign is_clear = !wr_rs && (wr_byte == CLEAR);
  assign busy     = busy_reg;
  assign lcd_rw   = 1'b0;

  // The next byte is issued in the same clock the previous cycle signals done.
  always_comb begin
    start   = 1'b0;
    wr_byte = 8'h00;
    wr_rs   = 1'b0;
    case (state_reg)
      ST_PWRUP: if (cnt_reg == CW'(PWRUP_WAIT - 1)) begin
        start   = 1'b1;
        wr_byte = init_cmd(2'd0);
      end
      ST_INIT: if (done && idx_reg != 4'd3) begin
        start   = 1'b1;
        wr_byte = init_cmd(idx_reg[1:0] + 2'd1);
      end
      ST_IDLE: if (mismatch) begin
        start   = 1'b1;
        wr_byte = CLEAR;
      end
      ST_CLEAR: if (done) begin
        start   = 1'b1;
        wr_byte = HOME_L1;
      end
      ST_HOME: if (done) begin
        start   = 1'b1;
        wr_rs   = 1'b1;
        wr_byte = msg_char(shown_reg, 4'd0);
      end
      ST_CHARS: if (done && idx_reg != 4'd15) begin
        start   = 1'b1;
        wr_rs   = 1'b1;
        wr_byte = msg_char(shown_reg, idx_reg + 4'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_PWRUP;
      cnt_reg         <= '0;
      idx_reg         <= 4'd0;
      shown_reg       <= 4'd0;
      shown_valid_reg <= 1'b0;
      busy_reg        <= 1'b1;
    end else begin
      case (state_reg)
        ST_PWRUP: begin
          if (cnt_reg == CW'(PWRUP_WAIT - 1)) begin
            state_reg <= ST_INIT;
            idx_reg   <= 4'd0;
          end else if (cnt_reg != {CW{1'b1}}) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        // busy stays high into IDLE: the invalid shown-code forces a rewrite
        ST_INIT: if (done) begin
          if (idx_reg == 4'd3) state_reg <= ST_IDLE;
          else                 idx_reg   <= idx_reg + 4'd1;
        end
        ST_IDLE: if (mismatch) begin
          shown_reg       <= code;
          shown_valid_reg <= 1'b1;
          state_reg       <= ST_CLEAR;
          busy_reg        <= 1'b1;
        end
        ST_CLEAR: if (done) state_reg <= ST_HOME;
        ST_HOME: if (done) begin
          state_reg <= ST_CHARS;
          idx_reg   <= 4'd0;
        end
        ST_CHARS: if (done) begin
          if (idx_reg == 4'd15) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            idx_reg <= idx_reg + 4'd1;
          end
        end
        default: state_reg <= ST_PWRUP;
      endcase
    end
  end

  lcd_bus_cycle #(
    .E_CYCLES(E_CYCLES),
    .CMD_WAIT(CMD_WAIT),
    .CLR_WAIT(CLR_WAIT),
    .CW      (CW)
  ) u_bus (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .wr_byte (wr_byte),
    .rs      (wr_rs),
    .is_clear(is_clear),
    .done    (done),
    .lcd_rs  (lcd_rs),
    .lcd_e   (lcd_e),
    .lcd_data(lcd_data)
  );

endmodule

// File: tb/tb_lcd_driver.sv
// Bench for lcd_driver: expected LCD write streams come from a line-level
// model (init list plus clear/home/16 chars per distinct displayed code).
module tb_lcd_driver;

  localparam int E_C    = 2;
  localparam int CMD_W  = 3;
  localparam int CLR_W  = 5;
  localparam int PW     = 10;
  localparam int WR_CMD = 1 + E_C + CMD_W;
  localparam int WR_CLR = 1 + E_C + CLR_W;
  localparam int INIT_LAT = PW + 3 * WR_CMD + WR_CLR;
  localparam int UPD_LAT  = 1 + WR_CLR + 17 * WR_CMD;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] code;
  logic       lcd_rs, lcd_rw, lcd_e, busy;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_driver #(
    .E_CYCLES(E_C), .CMD_WAIT(CMD_W), .CLR_WAIT(CLR_W), .PWRUP_WAIT(PW)
  ) dut (
    .clk(clk), .reset(reset), .code(code), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_data(lcd_data), .busy(busy)
  );

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus monitor: records every write and the strobe/gap timing around it.
  logic [8:0] got_q[$];
  int         rise_q[$];
  int         hi_q[$];
  int         gap_q[$];
  int         gapmin_q[$];
  int         unstable = 0;

  initial begin
    logic       e_prev;
    logic [8:0] hold;
    int         hi_cnt, last_fall, last_min;
    bit         have_fall;
    e_prev = 1'b0; have_fall = 0; hold = '0; hi_cnt = 0; last_fall = 0; last_min = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        e_prev    = 1'b0;
        have_fall = 0;
      end else begin
        if (lcd_e && !e_prev) begin
          hold = {lcd_rs, lcd_data};
          got_q.push_back(hold);
          rise_q.push_back(cyc);
          hi_cnt = 1;
          if (have_fall) begin
            gap_q.push_back(cyc - last_fall);
            gapmin_q.push_back(last_min);
          end
        end else if (lcd_e) begin
          hi_cnt++;
          if ({lcd_rs, lcd_data} !== hold || lcd_rw !== 1'b0) unstable++;
        end else if (e_prev) begin
          hi_q.push_back(hi_cnt);
          last_fall = cyc;
          have_fall = 1;
          last_min  = (hold == 9'h001) ? CLR_W + 1 : CMD_W + 1;
        end
        e_prev = lcd_e;
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  string msgs[10];

  function automatic logic [7:0] rom_char(input int c, input int i);
    string s;
    if (c > 9) return 8'h20;
    s = msgs[c];
    return s[i];
  endfunction

  logic [8:0] exp_q[$];
  int         shown;

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
  endtask

  task automatic push_rw(input int c);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, rom_char(c, i)});
  endtask

  task automatic cmp_writes(input string nm, input int base);
    int n;
    n = got_q.size() - base;
    check({nm, " write count"}, n, exp_q.size());
    if (n > exp_q.size()) n = exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s write %0d", nm, i), int'(got_q[base + i]), int'(exp_q[i]));
    $display("%s: %0d writes seen, %0d modelled", nm, got_q.size() - base, exp_q.size());
  endtask

  task automatic settle(input string nm);
    int quiet, n;
    quiet = 0; n = 0;
    while (quiet < 20 && n < 3000) begin
      @(negedge clk);
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    check({nm, " settled idle"}, quiet, 20);
  endtask

  task automatic powerup(input int c);
    int base, rb, rel, n;
    base = got_q.size();
    rb   = rise_q.size();
    exp_q = {};
    push_init();
    push_rw(c);
    rel   = cyc;
    reset = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 2000);
    check("powerup busy fall", n, INIT_LAT + UPD_LAT);
    check("powerup first strobe", (rise_q.size() > rb) ? rise_q[rb] - rel : -1, PW + 1);
    cmp_writes("powerup", base);
    shown = c;
  endtask

  typedef struct {
    logic [3:0] code;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base, n;
    logic [3:0] c1, c2;
    int d;

    msgs[0] = "INSERT COINS    ";
    msgs[1] = "SELECT ITEM     ";
    msgs[2] = "VENDING...      ";
    msgs[3] = "THANK YOU       ";
    msgs[4] = "SOLD OUT        ";
    msgs[5] = "EXACT CHANGE    ";
    msgs[6] = "RETURNING COINS ";
    msgs[7] = "TAKE CHANGE     ";
    msgs[8] = "SERVICE MODE    ";
    msgs[9] = "ERROR - CALL    ";

    vecs[0] = '{4'h3, UPD_LAT};
    vecs[1] = '{4'h3, 1};
    vecs[2] = '{4'hC, UPD_LAT};
    vecs[3] = '{4'h9, UPD_LAT};
    vecs[4] = '{4'hF, UPD_LAT};
    vecs[5] = '{4'h1, UPD_LAT};

    reset = 1'b0;
    code  = 4'h0;
    repeat (3) @(negedge clk);
    check("reset lcd_e", int'(lcd_e), 0);
    check("reset lcd_rs", int'(lcd_rs), 0);
    check("reset lcd_rw", int'(lcd_rw), 0);
    check("reset lcd_data", int'(lcd_data), 0);
    check("reset busy", int'(busy), 1);
    $display("reset: e=%0d rs=%0d data=%02h busy=%0d", lcd_e, lcd_rs, lcd_data, busy);

    powerup(0);

    base = got_q.size();
    repeat (500) @(negedge clk);
    check("steady no strobes", got_q.size() - base, 0);
    check("steady busy", int'(busy), 0);
    $display("steady: %0d strobes in 500 clocks, busy=%0d", got_q.size() - base, busy);

    foreach (vecs[k]) begin
      base  = got_q.size();
      exp_q = {};
      if (int'(vecs[k].code) != shown) begin
        push_rw(int'(vecs[k].code));
        shown = int'(vecs[k].code);
      end
      code = vecs[k].code;
      @(negedge clk);
      check($sformatf("vec%0d busy next clock", k), int'(busy), (vecs[k].lat > 1) ? 1 : 0);
      n = 1;
      while (busy && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("vec%0d busy latency", k), n, vecs[k].lat);
      settle($sformatf("vec%0d", k));
      cmp_writes($sformatf("vec%0d code=%0h", k, vecs[k].code), base);
    end

    // Changes while a rewrite is in flight: 5 is superseded before IDLE samples.
    base  = got_q.size();
    exp_q = {};
    push_rw(3);
    push_rw(7);
    code = 4'h3;
    repeat (60) @(negedge clk);
    code = 4'h5;
    repeat (10) @(negedge clk);
    code = 4'h7;
    settle("midchange");
    cmp_writes("midchange 3->5->7", base);
    shown = 7;

    for (int r = 0; r < 6; r++) begin
      c1 = 4'($urandom_range(0, 15));
      c2 = 4'($urandom_range(0, 15));
      d  = int'($urandom_range(1, 150));
      base  = got_q.size();
      exp_q = {};
      if (int'(c1) != shown) begin push_rw(int'(c1)); shown = int'(c1); end
      if (int'(c2) != shown) begin push_rw(int'(c2)); shown = int'(c2); end
      code = c1;
      repeat (d) @(negedge clk);
      code = c2;
      settle($sformatf("rand%0d", r));
      cmp_writes($sformatf("rand%0d %0h->%0h d=%0d", r, c1, c2, d), base);
    end

    // Reset during the strobe of character 8, then a full restart.
    c1   = 4'((shown + 5) % 16);
    code = c1;
    base = got_q.size();
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!((got_q.size() - base) == 11 && lcd_e) && n < 500);
    check("reached char8 strobe", got_q.size() - base, 11);
    reset = 1'b0;
    #1;
    check("midreset lcd_e", int'(lcd_e), 0);
    check("midreset lcd_data", int'(lcd_data), 0);
    check("midreset lcd_rs", int'(lcd_rs), 0);
    check("midreset busy", int'(busy), 1);
    $display("midreset: e=%0d rs=%0d data=%02h busy=%0d", lcd_e, lcd_rs, lcd_data, busy);
    repeat (3) @(negedge clk);
    powerup(int'(c1));

    foreach (hi_q[i]) check($sformatf("strobe width %0d", i), hi_q[i], E_C);
    foreach (gap_q[i]) check($sformatf("wait gap %0d", i), int'(gap_q[i] >= gapmin_q[i]), 1);
    check("bus stable during strobe", unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
